// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: register indices, widths and base types.
package mips_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;

    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned REG_SP   = 29;
    localparam int unsigned REG_RA   = 31;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

endpackage : mips_pkg

// File: rtl/reg_en.sv
// Generic W-bit register with synchronous active-low clear and load enable.
module reg_en #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Clear on reset, capture i_d when loaded, otherwise hold.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : reg_en

// File: rtl/reg_bank_ab.sv
// MIPS 32x32 register file with write-through bypass and A/B operand latches.
module reg_bank_ab #(
    parameter int unsigned DATA_W   = mips_pkg::DATA_W,
    parameter int unsigned ADDR_W   = mips_pkg::ADDR_W,
    parameter int unsigned SP_INDEX = mips_pkg::REG_SP,
    parameter int unsigned SP_RESET = 227
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] writeAddr,
    input  logic [DATA_W-1:0] writeData,
    input  logic [ADDR_W-1:0] readAddr1,
    input  logic [ADDR_W-1:0] readAddr2,
    input  logic              loadA,
    input  logic              loadB,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    output logic [DATA_W-1:0] regA,
    output logic [DATA_W-1:0] regB
);

    import mips_pkg::*;

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] IDX_ZERO = ADDR_W'(REG_ZERO);
    localparam logic [ADDR_W-1:0] IDX_SP   = ADDR_W'(SP_INDEX);
    localparam logic [DATA_W-1:0] SP_INIT  = DATA_W'(SP_RESET);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_wr_en;
    logic w_byp1;
    logic w_byp2;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    // Writes to register 0 are dropped so it reads as zero forever.
    assign w_wr_en = regWrite && (writeAddr != IDX_ZERO);

    // Storage array: reset defines every entry, then one write per cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= (ADDR_W'(i) == IDX_SP) ? SP_INIT : '0;
            end
        end else if (w_wr_en) begin
            r_mem[writeAddr] <= writeData;
        end
    end

    // Combinational read ports with same-cycle write-through bypass.
    always_comb begin
        w_byp1 = regWrite && (writeAddr == readAddr1);
        w_byp2 = regWrite && (writeAddr == readAddr2);
        w_rd1  = r_mem[readAddr1];
        w_rd2  = r_mem[readAddr2];
        if (readAddr1 == IDX_ZERO) begin
            w_rd1 = '0;
        end else if (w_byp1) begin
            w_rd1 = writeData;
        end
        if (readAddr2 == IDX_ZERO) begin
            w_rd2 = '0;
        end else if (w_byp2) begin
            w_rd2 = writeData;
        end
    end

    assign readData1 = w_rd1;
    assign readData2 = w_rd2;

    // Operand A latch, fed from the bypassed port-1 read.
    reg_en #(.W(DATA_W)) u_reg_a (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (loadA),
        .i_d     (w_rd1),
        .o_q     (regA)
    );

    // Operand B latch, fed from the bypassed port-2 read.
    reg_en #(.W(DATA_W)) u_reg_b (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (loadB),
        .i_d     (w_rd2),
        .o_q     (regB)
    );

endmodule : reg_bank_ab

// File: tb/tb_reg_bank_ab.sv
// Self-checking bench for reg_bank_ab: directed scenarios plus random traffic
// compared every cycle against an array-based reference model.
module tb_reg_bank_ab;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        regWrite;
    logic [4:0]  writeAddr;
    logic [31:0] writeData;
    logic [4:0]  readAddr1;
    logic [4:0]  readAddr2;
    logic        loadA;
    logic        loadB;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic [31:0] regA;
    logic [31:0] regB;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] m_mem [32];
    logic [31:0] m_a;
    logic [31:0] m_b;
    bit          m_valid = 1'b0;

    reg_bank_ab dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .regWrite  (regWrite),
        .writeAddr (writeAddr),
        .writeData (writeData),
        .readAddr1 (readAddr1),
        .readAddr2 (readAddr2),
        .loadA     (loadA),
        .loadB     (loadB),
        .readData1 (readData1),
        .readData2 (readData2),
        .regA      (regA),
        .regB      (regB)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // What a read of `a` must return given the current write inputs.
    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (regWrite && writeAddr == a) return writeData;
        return m_mem[a];
    endfunction

    // Apply inputs after the falling edge, then compare all outputs to the model.
    task automatic drive(input bit rst_n, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra1, input logic [4:0] ra2, input bit la, input bit lb);
        @(negedge clk);
        reset_n   = rst_n;
        regWrite  = we;
        writeAddr = wa;
        writeData = wd;
        readAddr1 = ra1;
        readAddr2 = ra2;
        loadA     = la;
        loadB     = lb;
        #1;
        if (m_valid) begin
            chk("model_rd1",  readData1, model_read(readAddr1));
            chk("model_rd2",  readData2, model_read(readAddr2));
            chk("model_regA", regA, m_a);
            chk("model_regB", regB, m_b);
        end
    endtask

    // Advance one rising edge and apply the same edge to the model.
    task automatic tick();
        logic [31:0] na;
        logic [31:0] nb;
        @(posedge clk);
        if (!reset_n) begin
            foreach (m_mem[i]) m_mem[i] = 32'd0;
            m_mem[29] = 32'd227;
            m_a = 32'd0;
            m_b = 32'd0;
            m_valid = 1'b1;
        end else begin
            na = loadA ? model_read(readAddr1) : m_a;
            nb = loadB ? model_read(readAddr2) : m_b;
            if (regWrite && writeAddr != 5'd0) m_mem[writeAddr] = writeData;
            m_a = na;
            m_b = nb;
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        regWrite  = 1'b0;
        writeAddr = '0;
        writeData = '0;
        readAddr1 = '0;
        readAddr2 = '0;
        loadA     = 1'b0;
        loadB     = 1'b0;

        // Reset for two cycles
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 1, 3, 32'hAAAA_5555, 0, 0, 1, 1); tick();

        // Reset values of every register on both ports, and the operand latches
        for (int i = 0; i < 32; i++) begin
            drive(1, 0, 0, 0, 5'(i), 5'(31 - i), 0, 0);
            chk("rst_rd1", readData1, (i == 29) ? 32'd227 : 32'd0);
            chk("rst_rd2", readData2, ((31 - i) == 29) ? 32'd227 : 32'd0);
            tick();
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_regA", regA, 32'd0);
        chk("rst_regB", regB, 32'd0);
        tick();

        // Hold and independence: load A from SP only
        drive(1, 0, 0, 0, 29, 8, 1, 0); tick();
        drive(1, 0, 0, 0, 3, 8, 0, 0);
        chk("hold_regA_sp", regA, 32'd227);
        chk("hold_regB",    regB, 32'd0);
        tick();
        drive(1, 0, 0, 0, 7, 9, 0, 0);
        chk("hold_regA_stable", regA, 32'd227);
        tick();

        // Write then read, then capture into A
        drive(1, 1, 8, 32'hDEAD_BEEF, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 8, 0, 1, 0);
        chk("wr8_rd1", readData1, 32'hDEAD_BEEF);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        chk("wr8_regA", regA, 32'hDEAD_BEEF);
        tick();

        // Register 0 is never written, even through the bypass
        drive(1, 1, 0, 32'hFFFF_FFFF, 0, 0, 1, 1);
        chk("r0_byp_rd1", readData1, 32'd0);
        chk("r0_byp_rd2", readData2, 32'd0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 1, 1);
        chk("r0_rd1", readData1, 32'd0);
        chk("r0_rd2", readData2, 32'd0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        chk("r0_regA", regA, 32'd0);
        chk("r0_regB", regB, 32'd0);
        tick();

        // Same-cycle write and load of B through the bypass
        drive(1, 1, 31, 32'h0040_0010, 0, 31, 0, 1);
        chk("byp_rd2", readData2, 32'h0040_0010);
        tick();
        drive(1, 0, 0, 0, 31, 31, 0, 0);
        chk("byp_regB", regB, 32'h0040_0010);
        chk("byp_mem31", readData1, 32'h0040_0010);
        tick();

        // Reset during a write discards the write and clears the latches
        drive(1, 1, 5, 32'h0000_1234, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 5, 0, 1, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        chk("mid_regA_pre", regA, 32'h0000_1234);
        tick();
        drive(0, 1, 5, 32'h0000_5678, 5, 5, 1, 1); tick();
        drive(1, 0, 0, 0, 5, 29, 0, 0);
        chk("mid_rd5",  readData1, 32'd0);
        chk("mid_rd29", readData2, 32'd227);
        chk("mid_regA", regA, 32'd0);
        chk("mid_regB", regB, 32'd0);
        tick();

        // Random traffic with frequent address collisions to exercise the bypass
        for (int n = 0; n < 3000; n++) begin
            bit          r_rst;
            bit          r_we;
            logic [4:0]  r_wa;
            logic [4:0]  r_ra1;
            logic [4:0]  r_ra2;
            r_rst = ($urandom_range(0, 99) < 2);
            r_we  = $urandom_range(0, 1) == 1;
            r_wa  = 5'($urandom_range(0, 31));
            r_ra1 = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom_range(0, 31));
            r_ra2 = ($urandom_range(0, 3) == 0) ? r_wa :
                    (($urandom_range(0, 7) == 0) ? r_ra1 : 5'($urandom_range(0, 31)));
            drive(!r_rst, r_we, r_wa, 32'($urandom), r_ra1, r_ra2,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            if (readAddr1 == readAddr2) chk("same_addr", readData1, readData2);
            tick();
        end

        drive(1, 0, 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_reg_bank_ab

// File: doc/reg_bank_ab.md
Name: reg_bank_ab

Overview:
- 32 x 32-bit MIPS general-purpose register file for the multicycle datapath.
- Its write-address input is driven directly by the 4:1 write-destination select mux (rt / rd / $ra / $sp selection, 5-bit output).
- Two combinational read ports feed the A and B operand registers, which are held inside this block and loaded under control-unit enables.
- Write-through bypass: a register written in the same cycle it is read delivers the new value to A/B.

Parameters:
- DATA_W, 32, register and data width.
- ADDR_W, 5, register index width; depth is 2**ADDR_W.
- SP_INDEX, 29, index of the stack pointer register.
- SP_RESET, 227, value loaded into SP_INDEX on reset.

Ports:
- clk  in  1  rising-edge clock, sole clock domain
- reset_n  in  1  synchronous, active-low reset
- regWrite  in  1  write enable from control unit
- writeAddr  in  ADDR_W  destination register index from the write-destination mux
- writeData  in  DATA_W  write-back data
- readAddr1  in  ADDR_W  rs index
- readAddr2  in  ADDR_W  rt index
- loadA  in  1  capture port-1 read data into regA
- loadB  in  1  capture port-2 read data into regB
- readData1  out  DATA_W  combinational port-1 read (bypassed)
- readData2  out  DATA_W  combinational port-2 read (bypassed)
- regA  out  DATA_W  registered operand A
- regB  out  DATA_W  registered operand B

Behaviour:
- Reset (reset_n==0 sampled at rising clk):
  - Every register clears to 0, except register SP_INDEX, which loads SP_RESET.
  - regA and regB clear to 0.
  - Reset overrides regWrite, loadA and loadB in the same cycle.
  - Asserting reset mid-operation discards any in-flight write.
- Write:
  - At the rising edge with reset_n==1 and regWrite==1, mem[writeAddr] <= writeData.
  - writeAddr==0 is ignored; register 0 stays 0 permanently.
  - Latency: the new value is visible in mem from the next cycle.
- Read (combinational, per port p):
  - If readAddrP==0: readDataP = 0.
  - Else if regWrite==1 and writeAddr==readAddrP: readDataP = writeData (bypass).
  - Else: readDataP = mem[readAddrP].
  - Both ports may address the same register; both return identical data.
- A/B latch:
  - At the rising edge with reset_n==1: if loadA, regA <= readData1; if loadB, regB <= readData2.
  - Otherwise each holds its value.
  - loadA and loadB are independent and may be asserted together.
  - Simultaneous write plus load of the same index captures writeData, through the bypass.
- No X propagation: all 32 entries are defined from reset.
- Write data width equals DATA_W; no truncation or extension inside the block.
- Simultaneous events in one cycle are all legal and have no ordering hazard: a write to N, a load of A from N, and a load of B from M.

Decomposition:
- Shared package mips_pkg:
  - REG_ZERO=0, REG_SP=29, REG_RA=31
  - DATA_W, ADDR_W
  - typedef reg_idx_t (logic [4:0])
  - typedef word_t (logic [31:0])
  - This package also serves the write-destination mux and the control unit.
- One sub-module: reg_en (DATA_W-wide register with synchronous active-low reset and load enable), instantiated twice for regA and regB.
- The storage array and bypass logic stay in reg_bank_ab.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles, release -> readData for every index 0..31 is 0 except index 29 = 227; regA = regB = 0.
- Write/read: regWrite=1, writeAddr=8, writeData=0xDEADBEEF for one cycle, then readAddr1=8 -> readData1=0xDEADBEEF. Pulse loadA -> regA=0xDEADBEEF on the next edge.
- Register 0 protection: regWrite=1, writeAddr=0, writeData=0xFFFFFFFF; then readAddr1=readAddr2=0 -> both reads 0; loadA=loadB=1 -> regA=regB=0.
- Bypass: same cycle regWrite=1, writeAddr=31, writeData=0x00400010, readAddr2=31, loadB=1 -> readData2=0x00400010 combinationally; regB=0x00400010 after the edge; mem[31]=0x00400010.
- Reset mid-operation: write 0x1234 to reg 5 and load A, then assert reset_n=0 in the same cycle as regWrite=1, writeAddr=5, writeData=0x5678 -> after the edge reg 5=0, regA=0, reg 29=227.
- Hold and independence: loadA=1, loadB=0 with readAddr1=29, readAddr2=8 after reset -> regA=227 and regB unchanged at 0. Deasserting loadA and changing readAddr1 leaves regA stable.
